generador_estimulos_alu: RTL and testbench
==========================================

Name: generador_estimulos_alu

Overview:
- Hardware initiator for the ALU load protocol, i.e. the driving end of the switches/buttons interface that `top_arquitectura` receives.
- Accepts one command (operand A, opcode, operand B) over a valid/ready handshake.
- Replays it as timed switch/button sequences: button 0 loads A, button 1 loads the opcode, button 2 loads B.
- Used for on-board self-test and as a reusable bench driver in place of hand-written delay stimulus.

Parameters:
- BUS_DATOS, 4, width of switches bus and operands.
- CANT_BOTONES_ALU, 4, width of buttons bus (bit 3 = clear strobe, see Optional Feature).
- CANT_BIT_OPCODE, 4, opcode width; must be <= BUS_DATOS.
- CICLOS_SETUP, 2, cycles switches are stable before a button rises (>=1).
- CICLOS_PULSO, 4, cycles a button is held high (>=1).
- CICLOS_GAP, 2, cycles with all buttons low after a button falls (>=1).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  command valid.
- i_dato_a  in  BUS_DATOS  operand A.
- i_opcode  in  CANT_BIT_OPCODE  operation code.
- i_dato_b  in  BUS_DATOS  operand B.
- o_ready  out  1  block idle, able to accept a command.
- o_switches  out  BUS_DATOS  driven switches value.
- o_botones  out  CANT_BOTONES_ALU  driven buttons, at most one bit high.
- o_done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_ready=1, o_switches=0, o_botones=0, o_done=0, all counters 0, captured command cleared.
- Handshake:
  - Capture occurs on a rising edge with i_valid && o_ready; A, opcode and B are registered together.
  - o_ready falls the next cycle and stays 0 until the return to IDLE.
  - Input changes while o_ready=0 are ignored.
- Phase index f = 0, 1, 2 selects the value driven on o_switches:
  - f=0: A.
  - f=1: opcode, zero-extended to BUS_DATOS.
  - f=2: B.
- FSM states: IDLE -> SETUP -> PULSO -> GAP -> (SETUP with f+1 | FIN) -> IDLE.
  - SETUP: o_switches = value(f), o_botones=0. Runs CICLOS_SETUP cycles.
  - PULSO: o_botones[f]=1, o_switches held. Runs CICLOS_PULSO cycles.
  - GAP: o_botones=0, o_switches held at value(f). Runs CICLOS_GAP cycles. Then f==2 -> FIN, else f+1 -> SETUP.
  - FIN: one cycle, o_done=1. Then IDLE, o_ready=1, o_switches keeps the last value (B).
- A single down-counter reloads on every state entry.
  - Counter width is clog2 of the maximum of the three CICLOS parameters, plus 1.
  - The state advances when the counter reaches 1.
- All outputs are registered.
- Latency from the capture edge to o_done = 3*(CICLOS_SETUP+CICLOS_PULSO+CICLOS_GAP)+1 cycles; 25 with defaults.
- Back-to-back commands: i_valid held high is accepted on the first cycle o_ready=1, so one idle cycle separates sequences.
- Switches never change while any button is high. Buttons never overlap.
- Reset mid-sequence: all outputs return to reset values immediately (asynchronous). A partial command is discarded and never resumed.
- o_botones bits above index 2 stay 0 unless the Optional Feature is enabled.

Optional Feature:
- Macro: GENERADOR_PULSO_CLEAR_EN.
- Defined:
  - The sequence gains a leading clear phase f=-1 (SETUP/PULSO/GAP with o_switches=0 and o_botones[3]=1) before A.
  - Latency rises by CICLOS_SETUP+CICLOS_PULSO+CICLOS_GAP; 33 with defaults.
  - Requires CANT_BOTONES_ALU >= 4.
- Undefined: no clear phase; o_botones[3] is tied to 0.

Decomposition:
- Shared package `alu_pkg` holds:
  - State encodings (IDLE, SETUP, PULSO, GAP, FIN).
  - Button index constants: BOTON_A=0, BOTON_OP=1, BOTON_B=2, BOTON_CLEAR=3.
  - The default ADD opcode 4'b1000.
- One sub-module, `contador_fase`: loadable down-counter with a terminal-count flag, reused for all three timings.

Test Plan:
- Reset held, then released: o_ready=1, o_switches=0000, o_botones=0000, o_done=0.
- Command A=0101, op=1000 (ADD), B=0101:
  - o_botones pulses 0001, 0010, 0100, each exactly 4 cycles.
  - o_switches shows 0101, 1000, 0101, each stable 2 cycles before and 2 cycles after its pulse.
  - o_done pulses on cycle 25 after capture.
- i_valid held high with A=1111, op=0010, B=0011 for two commands: the second capture occurs one cycle after the first o_done; i_dato_a changes during the busy window are ignored.
- Assert i_reset during PULSO of phase 1:
  - o_botones=0 and o_switches=0 within the same cycle.
  - o_ready=1 after release; no o_done is produced.
- Corner timing CICLOS_SETUP=CICLOS_PULSO=CICLOS_GAP=1: buttons 1-cycle wide, latency 10, no overlap.
- With GENERADOR_PULSO_CLEAR_EN: o_botones=1000 pulse with o_switches=0000 precedes the 0001 pulse; latency 33.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM states, button indices and opcode constants for the ALU stimulus generator
package alu_pkg;

    // Sequencer states of generador_estimulos_alu.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSO = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } estado_t;

    // Button bit driven during each load phase.
    localparam int BOTON_A     = 0;
    localparam int BOTON_OP    = 1;
    localparam int BOTON_B     = 2;
    localparam int BOTON_CLEAR = 3;

    // Phase index encoding. The clear phase uses code 3 so that a plain
    // 2-bit increment walks clear -> A -> opcode -> B.
    localparam logic [1:0] FASE_A     = 2'd0;
    localparam logic [1:0] FASE_OP    = 2'd1;
    localparam logic [1:0] FASE_B     = 2'd2;
    localparam logic [1:0] FASE_CLEAR = 2'd3;

    // Default ADD opcode of the target ALU.
    localparam logic [3:0] OPCODE_ADD = 4'b1000;

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - loadable down-counter with terminal-count flag for phase timing
//
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   carga, valor : load strobe and reload value (takes priority over counting)
//   fin          : high while the count equals 1 (last cycle of the timed state)
module contador_fase #(
    parameter int ANCHO = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carga,
    input  logic [ANCHO-1:0] valor,
    output logic             fin
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - ANCHO'(1);
        end
    end

    assign fin = (cuenta == ANCHO'(1));

endmodule

// File: rtl/generador_estimulos_alu.sv
// rtl/generador_estimulos_alu.sv - replays one ALU command as timed switch/button load sequences
//
// Optional clear phase: macro GENERADOR_PULSO_CLEAR_EN (adds a leading
// o_switches=0 / o_botones[3] pulse phase; requires CANT_BOTONES_ALU >= 4).
//
// Ports:
//   i_clock, i_reset             : clock, asynchronous active-high reset
//   i_valid, o_ready             : command handshake, capture on i_valid && o_ready
//   i_dato_a, i_opcode, i_dato_b : command fields, registered together at capture
//   o_switches, o_botones        : driven switch value and one-hot button strobes
//   o_done                       : one-cycle pulse when the sequence completes
module generador_estimulos_alu
    import alu_pkg::*;
#(
    parameter int BUS_DATOS        = 4,
    parameter int CANT_BOTONES_ALU = 4,
    parameter int CANT_BIT_OPCODE  = 4,
    parameter int CICLOS_SETUP     = 2,
    parameter int CICLOS_PULSO     = 4,
    parameter int CICLOS_GAP       = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [BUS_DATOS-1:0]        i_dato_a,
    input  logic [CANT_BIT_OPCODE-1:0]  i_opcode,
    input  logic [BUS_DATOS-1:0]        i_dato_b,
    output logic                        o_ready,
    output logic [BUS_DATOS-1:0]        o_switches,
    output logic [CANT_BOTONES_ALU-1:0] o_botones,
    output logic                        o_done
);

    localparam int CICLOS_MAX =
        (CICLOS_SETUP > CICLOS_PULSO) ?
            ((CICLOS_SETUP > CICLOS_GAP) ? CICLOS_SETUP : CICLOS_GAP) :
            ((CICLOS_PULSO > CICLOS_GAP) ? CICLOS_PULSO : CICLOS_GAP);
    localparam int ANCHO_CNT = $clog2(CICLOS_MAX) + 1;

`ifdef GENERADOR_PULSO_CLEAR_EN
    localparam logic [1:0] FASE_INICIAL = FASE_CLEAR;
`else
    localparam logic [1:0] FASE_INICIAL = FASE_A;
`endif

    estado_t                      estado, estado_sig;
    logic [1:0]                   fase, fase_sig;
    logic [BUS_DATOS-1:0]         dato_a, dato_a_sig;
    logic [BUS_DATOS-1:0]         dato_b, dato_b_sig;
    logic [CANT_BIT_OPCODE-1:0]   opcode, opcode_sig;
    logic [BUS_DATOS-1:0]         switches_sig;
    logic [CANT_BOTONES_ALU-1:0]  botones_sig;
    logic                         ready_sig;
    logic                         done_sig;
    logic                         carga;
    logic [ANCHO_CNT-1:0]         valor_cuenta;
    logic                         fin_cuenta;

    function automatic logic [BUS_DATOS-1:0] valor_fase(
        input logic [1:0]                 f,
        input logic [BUS_DATOS-1:0]       a,
        input logic [CANT_BIT_OPCODE-1:0] op,
        input logic [BUS_DATOS-1:0]       b
    );
        case (f)
            FASE_A:  valor_fase = a;
            FASE_OP: valor_fase = BUS_DATOS'(op);
            FASE_B:  valor_fase = b;
            default: valor_fase = '0;
        endcase
    endfunction

    contador_fase #(
        .ANCHO (ANCHO_CNT)
    ) u_contador (
        .clock (i_clock),
        .reset (i_reset),
        .carga (carga),
        .valor (valor_cuenta),
        .fin   (fin_cuenta)
    );

    always_comb begin
        estado_sig = estado;
        fase_sig   = fase;
        dato_a_sig = dato_a;
        dato_b_sig = dato_b;
        opcode_sig = opcode;

        case (estado)
            IDLE: begin
                if (i_valid && o_ready) begin
                    estado_sig = SETUP;
                    fase_sig   = FASE_INICIAL;
                    dato_a_sig = i_dato_a;
                    opcode_sig = i_opcode;
                    dato_b_sig = i_dato_b;
                end
            end
            SETUP: if (fin_cuenta) estado_sig = PULSO;
            PULSO: if (fin_cuenta) estado_sig = GAP;
            GAP: begin
                if (fin_cuenta) begin
                    if (fase == FASE_B) begin
                        estado_sig = FIN;
                    end else begin
                        estado_sig = SETUP;
                        fase_sig   = fase + 2'd1;
                    end
                end
            end
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase

        // Every state has a distinct successor, so a state change is the
        // reload event for the shared timer.
        carga = (estado_sig != estado);

        // Outputs are decoded from the next state so they register in step
        // with it; o_switches holds its value outside SETUP entry.
        valor_cuenta = '0;
        switches_sig = o_switches;
        botones_sig  = '0;
        ready_sig    = 1'b0;
        done_sig     = 1'b0;
        case (estado_sig)
            IDLE:  ready_sig = 1'b1;
            SETUP: begin
                valor_cuenta = ANCHO_CNT'(CICLOS_SETUP);
                switches_sig = valor_fase(fase_sig, dato_a_sig, opcode_sig, dato_b_sig);
            end
            PULSO: begin
                valor_cuenta = ANCHO_CNT'(CICLOS_PULSO);
                for (int i = 0; i < CANT_BOTONES_ALU; i++) begin
`ifdef GENERADOR_PULSO_CLEAR_EN
                    botones_sig[i] = (int'(fase_sig) == i);
`else
                    botones_sig[i] = (int'(fase_sig) == i) && (i != BOTON_CLEAR);
`endif
                end
            end
            GAP:   valor_cuenta = ANCHO_CNT'(CICLOS_GAP);
            FIN: begin
                valor_cuenta = ANCHO_CNT'(1);
                done_sig     = 1'b1;
            end
            default: ready_sig = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            estado     <= IDLE;
            fase       <= FASE_A;
            dato_a     <= '0;
            dato_b     <= '0;
            opcode     <= '0;
            o_ready    <= 1'b1;
            o_switches <= '0;
            o_botones  <= '0;
            o_done     <= 1'b0;
        end else begin
            estado     <= estado_sig;
            fase       <= fase_sig;
            dato_a     <= dato_a_sig;
            dato_b     <= dato_b_sig;
            opcode     <= opcode_sig;
            o_ready    <= ready_sig;
            o_switches <= switches_sig;
            o_botones  <= botones_sig;
            o_done     <= done_sig;
        end
    end

endmodule

// File: tb/tb_generador_estimulos_alu.sv
// tb/tb_generador_estimulos_alu.sv - self-checking bench for generador_estimulos_alu (default and 1/1/1 timing instances)
module tb_generador_estimulos_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       sel;
    logic [3:0] a, op, b;

    logic       rdy_d, done_d, rdy_m, done_m;
    logic [3:0] sw_d, bt_d, sw_m, bt_m;
    logic       obs_ready, obs_done;
    logic [3:0] obs_sw, obs_bt;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_sw[$];
    logic [3:0] q_bt[$];
    logic       q_done[$];

    always #5 clk = ~clk;

    generador_estimulos_alu dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_valid    (valid & ~sel),
        .i_dato_a   (a),
        .i_opcode   (op),
        .i_dato_b   (b),
        .o_ready    (rdy_d),
        .o_switches (sw_d),
        .o_botones  (bt_d),
        .o_done     (done_d)
    );

    generador_estimulos_alu #(
        .CICLOS_SETUP (1),
        .CICLOS_PULSO (1),
        .CICLOS_GAP   (1)
    ) dut_min (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_valid    (valid & sel),
        .i_dato_a   (a),
        .i_opcode   (op),
        .i_dato_b   (b),
        .o_ready    (rdy_m),
        .o_switches (sw_m),
        .o_botones  (bt_m),
        .o_done     (done_m)
    );

    assign obs_ready = sel ? rdy_m  : rdy_d;
    assign obs_sw    = sel ? sw_m   : sw_d;
    assign obs_bt    = sel ? bt_m   : bt_d;
    assign obs_done  = sel ? done_m : done_d;

    // Expected per-cycle trace after the capture edge: each phase is
    // s cycles of value, p cycles of value with its button, g cycles of
    // value, followed by a single done cycle still showing B.
    function automatic void modelo(input logic [3:0] ca, input logic [3:0] cop,
                                   input logic [3:0] cb, input int s, input int p, input int g);
        int vals[$];
        int btns[$];
        q_sw.delete();
        q_bt.delete();
        q_done.delete();
`ifdef GENERADOR_PULSO_CLEAR_EN
        vals.push_back(0);
        btns.push_back(3);
`endif
        vals.push_back(int'(ca));  btns.push_back(0);
        vals.push_back(int'(cop)); btns.push_back(1);
        vals.push_back(int'(cb));  btns.push_back(2);
        for (int k = 0; k < vals.size(); k++) begin
            for (int c = 0; c < s + p + g; c++) begin
                q_sw.push_back(4'(vals[k]));
                q_bt.push_back((c >= s && c < s + p) ? 4'(1 << btns[k]) : 4'b0000);
                q_done.push_back(1'b0);
            end
        end
        q_sw.push_back(cb);
        q_bt.push_back(4'b0000);
        q_done.push_back(1'b1);
    endfunction

    task automatic correr_secuencia(input string nombre, input bit usar_min,
                                    input logic [3:0] ca, input logic [3:0] cop, input logic [3:0] cb,
                                    input int s, input int p, input int g, output int ciclo_done);
        sel = usar_min;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_capture: got %b expected 1", nombre, obs_ready);
        end
        a = ca; op = cop; b = cb; valid = 1'b1;
        modelo(ca, cop, cb, s, p, g);
        @(posedge clk);
        #1;
        valid = 1'b0;
        a = 4'($urandom); op = 4'($urandom); b = 4'($urandom);
        ciclo_done = 0;
        for (int n = 1; n <= q_sw.size(); n++) begin
            @(negedge clk);
            checks++;
            if (obs_sw !== q_sw[n-1]) begin
                errors++;
                $display("FAIL %s switches cycle %0d: got %b expected %b", nombre, n, obs_sw, q_sw[n-1]);
            end
            checks++;
            if (obs_bt !== q_bt[n-1]) begin
                errors++;
                $display("FAIL %s botones cycle %0d: got %b expected %b", nombre, n, obs_bt, q_bt[n-1]);
            end
            checks++;
            if (obs_done !== q_done[n-1]) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", nombre, n, obs_done, q_done[n-1]);
            end
            checks++;
            if (obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_busy cycle %0d: got %b expected 0", nombre, n, obs_ready);
            end
            if (obs_done === 1'b1 && ciclo_done == 0) ciclo_done = n;
        end
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1 || obs_sw !== cb || obs_bt !== 4'b0000 || obs_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got ready=%b sw=%b bt=%b done=%b expected ready=1 sw=%b bt=0000 done=0",
                     nombre, obs_ready, obs_sw, obs_bt, obs_done, cb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; sel = 1'b0; a = '0; op = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy_d, sw_d, bt_d, done_d} !== {1'b1, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_held_default: got ready=%b sw=%b bt=%b done=%b expected 1 0000 0000 0", rdy_d, sw_d, bt_d, done_d);
        end
        checks++;
        if ({rdy_m, sw_m, bt_m, done_m} !== {1'b1, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_held_min: got ready=%b sw=%b bt=%b done=%b expected 1 0000 0000 0", rdy_m, sw_m, bt_m, done_m);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy_d, sw_d, bt_d, done_d} !== {1'b1, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_released: got ready=%b sw=%b bt=%b done=%b expected 1 0000 0000 0", rdy_d, sw_d, bt_d, done_d);
        end
    endtask

    task automatic test_comando_add();
        int cd;
        int lat;
`ifdef GENERADOR_PULSO_CLEAR_EN
        lat = 33;
`else
        lat = 25;
`endif
        correr_secuencia("add", 1'b0, 4'b0101, alu_pkg::OPCODE_ADD, 4'b0101, 2, 4, 2, cd);
        checks++;
        if (cd !== lat) begin
            errors++;
            $display("FAIL add_latency: got %0d expected %0d", cd, lat);
        end
    endtask

    task automatic test_back_to_back();
        int largo;
        sel = 1'b0;
        @(negedge clk);
        a = 4'b1111; op = 4'b0010; b = 4'b0011; valid = 1'b1;
        modelo(4'b1111, 4'b0010, 4'b0011, 2, 4, 2);
        largo = q_sw.size();
        for (int cmd = 0; cmd < 2; cmd++) begin
            @(posedge clk);
            for (int n = 1; n <= largo; n++) begin
                @(negedge clk);
                checks++;
                if (sw_d !== q_sw[n-1] || bt_d !== q_bt[n-1] || done_d !== q_done[n-1] || rdy_d !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b cmd %0d cycle %0d: got sw=%b bt=%b done=%b ready=%b expected sw=%b bt=%b done=%b ready=0",
                             cmd, n, sw_d, bt_d, done_d, rdy_d, q_sw[n-1], q_bt[n-1], q_done[n-1]);
                end
                if (n == 1) a = 4'($urandom);
                if (n == largo) a = 4'b1111;
            end
            @(negedge clk);
            checks++;
            if (rdy_d !== 1'b1 || done_d !== 1'b0) begin
                errors++;
                $display("FAIL b2b idle_gap cmd %0d: got ready=%b done=%b expected ready=1 done=0", cmd, rdy_d, done_d);
            end
            if (cmd == 1) valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (rdy_d !== 1'b1) begin
            errors++;
            $display("FAIL b2b no_third_capture: got ready=%b expected 1", rdy_d);
        end
    endtask

    task automatic test_reset_en_pulso();
        int n_pulso;
        bit vio_done;
        n_pulso = 8 + 2 + 1;
`ifdef GENERADOR_PULSO_CLEAR_EN
        n_pulso = n_pulso + 8;
`endif
        sel = 1'b0;
        @(negedge clk);
        a = 4'($urandom); op = 4'($urandom); b = 4'($urandom); valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (n_pulso) @(negedge clk);
        checks++;
        if (bt_d !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid pulse_phase1: got %b expected 0010", bt_d);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bt_d !== 4'b0000 || sw_d !== 4'b0000 || done_d !== 1'b0 || rdy_d !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid async: got bt=%b sw=%b done=%b ready=%b expected 0000 0000 0 1", bt_d, sw_d, done_d, rdy_d);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vio_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_d !== 1'b0 || bt_d !== 4'b0000 || rdy_d !== 1'b1) vio_done = 1'b1;
        end
        checks++;
        if (vio_done) begin
            errors++;
            $display("FAIL rst_mid resumed: got activity after reset expected idle (done=0 bt=0000 ready=1)");
        end
    endtask

    task automatic test_esquina();
        int cd;
        int lat;
`ifdef GENERADOR_PULSO_CLEAR_EN
        lat = 13;
`else
        lat = 10;
`endif
        for (int k = 0; k < 4; k++) begin
            correr_secuencia("corner", 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1, cd);
            checks++;
            if (cd !== lat) begin
                errors++;
                $display("FAIL corner_latency %0d: got %0d expected %0d", k, cd, lat);
            end
        end
    endtask

    task automatic test_aleatorio();
        int cd;
        for (int k = 0; k < 5; k++) begin
            correr_secuencia("random", 1'b0, 4'($urandom), 4'($urandom_range(0, 15)), 4'($urandom), 2, 4, 2, cd);
        end
    endtask

    initial begin
        test_reset();
        test_comando_add();
        test_back_to_back();
        test_reset_en_pulso();
        test_esquina();
        test_aleatorio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
